// File: rtl/master_in_port_if.sv
`default_nettype none
// ============================================================================
// Module   : master_in_port_if
// Brief    : Handshake and serial-data bundle between the master receive port
//            and the slave serial output port.
// Revision : 1.0 - initial release
// ============================================================================
interface master_in_port_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  master_en;
  logic                  slave_valid;
  logic                  rx_data;
  logic                  master_ready;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  rx_done;
  logic                  rx_err;
  logic                  busy;

  // master: the receive port itself; slave: the side driving frames into it
  modport master (
    input  master_en, slave_valid, rx_data,
    output master_ready, data_out, rx_done, rx_err, busy
  );

  modport slave (
    output master_en, slave_valid, rx_data,
    input  master_ready, data_out, rx_done, rx_err, busy
  );
endinterface
`default_nettype wire

// File: rtl/master_in_port.sv
`default_nettype none
// ============================================================================
// Module   : master_in_port
// Brief    : Master-side serial receive port; grants the bus, shifts in an
//            LSB-first frame and presents the word with a done/err pulse.
// Revision : 1.0 - initial release
// ============================================================================
module master_in_port #(
  parameter int DATA_WIDTH = 8
) (
  input  wire                 clk,
  input  wire                 reset,
  master_in_port_if.master    bus
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    RECV  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  rx_err_q, rx_err_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_out_q <= '0;
      rx_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_out_q <= data_out_d;
      rx_err_q   <= rx_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_out_d = data_out_q;
    rx_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.master_en) begin
          state_d = READY;
        end
      end

      READY: begin
        // A pending slave frame wins over a withdrawn request on the same edge
        if (bus.slave_valid) begin
          state_d   = RECV;
          bit_cnt_d = '0;
          shift_d   = '0;
        end else if (!bus.master_en) begin
          state_d = IDLE;
        end
      end

      RECV: begin
        if (!bus.slave_valid) begin
          state_d   = IDLE;
          rx_err_d  = 1'b1;
          bit_cnt_d = '0;
          shift_d   = '0;
        end else begin
          shift_d[bit_cnt_q] = bus.rx_data;
          if (bit_cnt_q == LAST_BIT) begin
            // Counter parks on the last bit; the next handshake clears it
            data_out_d = shift_d;
            state_d    = DONE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

      DONE: begin
        state_d = bus.master_en ? READY : IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.master_ready = (state_q == READY);
  assign bus.busy         = (state_q == RECV) || (state_q == DONE);
  assign bus.rx_done      = (state_q == DONE);
  assign bus.rx_err       = rx_err_q;
  assign bus.data_out     = data_out_q;

endmodule
`default_nettype wire

// File: tb/tb_master_in_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_master_in_port
// Brief    : Directed self-checking bench for master_in_port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_master_in_port;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   cyc;
  int   done_cyc;
  int   first_done_cyc;

  master_in_port_if #(.DATA_WIDTH(8)) bus ();

  master_in_port #(.DATA_WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc = cyc + 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts in READY; leaves the DUT in DONE with slave_valid still high.
  task automatic recv_frame(input logic [7:0] w, input string tag);
    bus.slave_valid = 1'b1;
    tick();
    chk({tag, "_h_ready"}, bus.master_ready, 1'b0);
    chk({tag, "_h_busy"}, bus.busy, 1'b1);
    for (int i = 0; i < 8; i++) begin
      bus.rx_data = w[i];
      tick();
      if (i < 7) begin
        chk({tag, "_recv_flags"},
            {bus.master_ready, bus.rx_done, bus.rx_err, bus.busy}, 4'b0001);
      end else begin
        chk({tag, "_done"}, bus.rx_done, 1'b1);
        chk({tag, "_data"}, bus.data_out, w);
        chk({tag, "_err"}, bus.rx_err, 1'b0);
        chk({tag, "_busy_done"}, bus.busy, 1'b1);
        done_cyc = cyc;
      end
    end
  endtask

  initial begin
    total           = 0;
    bad             = 0;
    cyc             = 0;
    done_cyc        = 0;
    first_done_cyc  = 0;
    reset           = 1'b1;
    bus.master_en   = 1'b0;
    bus.slave_valid = 1'b0;
    bus.rx_data     = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("reset_outputs",
        {bus.master_ready, bus.rx_done, bus.rx_err, bus.busy, bus.data_out}, 12'h000);
    reset = 1'b0;

    // Basic frame 8'hAA
    bus.master_en = 1'b1;
    tick();
    chk("basic_ready", bus.master_ready, 1'b1);
    chk("basic_ready_notbusy", bus.busy, 1'b0);
    recv_frame(8'hAA, "basic");
    bus.slave_valid = 1'b0;
    tick();
    chk("basic_after_done",
        {bus.master_ready, bus.rx_done, bus.busy}, 3'b100);

    // Back-to-back 8'h3C then 8'hC3
    recv_frame(8'h3C, "b2b1");
    first_done_cyc = done_cyc;
    tick();
    chk("b2b_ready_after_done", bus.master_ready, 1'b1);
    chk("b2b_done_low", bus.rx_done, 1'b0);
    recv_frame(8'hC3, "b2b2");
    chk("b2b_spacing", done_cyc - first_done_cyc, 10);
    bus.slave_valid = 1'b0;
    tick();

    // Abort after 4 bits of the frame following 8'h55
    recv_frame(8'h55, "abort_load");
    bus.slave_valid = 1'b0;
    tick();
    bus.slave_valid = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      bus.rx_data = 1'b1;
      tick();
    end
    bus.slave_valid = 1'b0;
    tick();
    chk("abort_err", bus.rx_err, 1'b1);
    chk("abort_flags", {bus.master_ready, bus.rx_done, bus.busy}, 3'b000);
    chk("abort_data_kept", bus.data_out, 8'h55);
    tick();
    chk("abort_err_pulse", bus.rx_err, 1'b0);
    chk("abort_back_ready", bus.master_ready, 1'b1);
    chk("abort_data_kept2", bus.data_out, 8'h55);

    // Withdraw request without a frame
    tick();
    chk("withdraw_hold", bus.master_ready, 1'b1);
    bus.master_en = 1'b0;
    tick();
    chk("withdraw_drop",
        {bus.master_ready, bus.rx_done, bus.rx_err, bus.busy}, 4'b0000);
    // Withdraw on the same edge as slave_valid: frame still accepted
    bus.master_en = 1'b1;
    tick();
    chk("withdraw_reready", bus.master_ready, 1'b1);
    bus.master_en = 1'b0;
    recv_frame(8'hF0, "withdraw_race");
    bus.slave_valid = 1'b0;
    tick();
    chk("withdraw_to_idle", {bus.master_ready, bus.busy}, 2'b00);

    // Reset in the middle of a frame
    bus.master_en = 1'b1;
    tick();
    bus.slave_valid = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      bus.rx_data = 1'b1;
      tick();
    end
    reset = 1'b1;
    tick();
    chk("midreset_outputs",
        {bus.master_ready, bus.rx_done, bus.rx_err, bus.busy, bus.data_out}, 12'h000);
    reset = 1'b0;
    tick();
    chk("midreset_ready", bus.master_ready, 1'b1);
    recv_frame(8'h81, "post_reset");
    bus.slave_valid = 1'b0;
    bus.master_en   = 1'b0;
    tick();

    // Idle stability with noisy slave inputs
    for (int i = 0; i < 20; i++) begin
      bus.slave_valid = 1'($urandom_range(0, 1));
      bus.rx_data     = 1'($urandom_range(0, 1));
      tick();
      chk("idle_stable",
          {bus.master_ready, bus.rx_done, bus.rx_err, bus.busy, bus.data_out}, 12'h081);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
